// File: rtl/comb_sweep_chk.sv
// comb_sweep_chk
//   Exhaustive sweep checker for small combinational leaf blocks. Drives every
//   input vector 0 .. 2^N_IN-1, holds each one for HOLD cycles, samples the
//   response on the last hold cycle and compares it with a truth table that is
//   latched at start. Reports pass/fail, mismatch count and first failing vector.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; stim parked at 0
//   RUN   | sweeping; hold_cnt counts down, sample on terminal count
//   FIN   | one cycle after the final sample; done pulse visible here
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   start           begin a sweep (only honoured in IDLE)
//   expect_tt       expected table, entry v = expect_tt[v*N_OUT +: N_OUT]
//   resp            response of the block under check to stim
//   stim            registered vector driven to the block under check
//   busy            high while a sweep is running
//   done            one-cycle pulse at sweep end
//   pass            last sweep had zero mismatches (held until next start)
//   err_count       mismatch count of the current/last sweep
//   first_err_vec   stim value of the first mismatch
//   first_err_valid first_err_vec is meaningful

module comb_sweep_chk #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1,
    parameter int HOLD  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [N_OUT*(2**N_IN)-1:0]   expect_tt,
    input  logic [N_OUT-1:0]             resp,
    output logic [N_IN-1:0]              stim,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [N_IN:0]                err_count,
    output logic [N_IN-1:0]              first_err_vec,
    output logic                         first_err_valid
);

    localparam int TT_W = N_OUT * (2**N_IN);
    localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD - 1);
    localparam logic [HC_W-1:0] HC_ONE    = HC_W'(1);
    localparam logic [N_IN-1:0] STIM_ONE  = N_IN'(1);
    localparam logic [N_IN-1:0] STIM_LAST = '1;
    localparam logic [N_IN:0]   ERR_ONE   = (N_IN + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [HC_W-1:0]   hold_cnt;
    logic [TT_W-1:0]   tt_q;
    logic [N_OUT-1:0]  exp_entry;

    logic              launch;
    logic              sample;
    logic              last;
    logic              mismatch;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last)  state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control strobes decoded from state
    always_comb begin
        launch    = 1'b0;
        sample    = 1'b0;
        last      = 1'b0;
        exp_entry = tt_q[int'(stim) * N_OUT +: N_OUT];
        // Any differing bit makes the whole vector a single mismatch.
        mismatch  = (resp != exp_entry);
        case (state)
            S_IDLE: launch = start;
            S_RUN: begin
                sample = (hold_cnt == '0);
                last   = (hold_cnt == '0) && (stim == STIM_LAST);
            end
            default: ;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_q            <= '0;
            hold_cnt        <= '0;
            stim            <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (launch) begin
                tt_q            <= expect_tt;
                stim            <= '0;
                hold_cnt        <= HOLD_LOAD;
                err_count       <= '0;
                pass            <= 1'b0;
                first_err_vec   <= '0;
                first_err_valid <= 1'b0;
                busy            <= 1'b1;
            end else if (state == S_RUN) begin
                if (!sample) begin
                    hold_cnt <= hold_cnt - HC_ONE;
                end else begin
                    if (mismatch) begin
                        err_count <= err_count + ERR_ONE;
                        if (!first_err_valid) begin
                            first_err_vec   <= stim;
                            first_err_valid <= 1'b1;
                        end
                    end
                    if (last) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        // err_count has not yet absorbed this final sample.
                        pass <= (err_count == '0) && !mismatch;
                        stim <= '0;
                    end else begin
                        stim     <= stim + STIM_ONE;
                        hold_cnt <= HOLD_LOAD;
                    end
                end
            end
        end
    end

endmodule

// File: doc/comb_sweep_chk.md
Name: comb_sweep_chk

Overview:
Parametrised, synthesisable exhaustive-sweep checker for small combinational blocks.
- Drives every input vector 0 .. 2^N_IN-1 to a device under check.
- Holds each vector for HOLD cycles, then samples the response and compares it against an expected truth table.
- Reports pass/fail, the error count and the first failing vector.
- Sits beside combinational leaf modules for on-chip or bench self-test.
- Adds multi-output support, settle time and automatic checking.

Parameters:
N_IN, 3, number of DUT inputs (1..8); stim width
N_OUT, 1, number of DUT outputs (1..8); resp width
HOLD, 1, cycles each vector is held before sampling (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; sampled only in IDLE
expect_tt  input  N_OUT*2^N_IN  expected table; entry v = expect_tt[v*N_OUT +: N_OUT]
resp  input  N_OUT  DUT response to stim
stim  output  N_IN  vector driven to DUT, registered
busy  output  1  high while a sweep is running
done  output  1  one-cycle pulse at sweep end
pass  output  1  high when the last sweep had zero errors; held until the next start
err_count  output  N_IN+1  mismatches in the current/last sweep; cannot overflow, max 2^N_IN
first_err_vec  output  N_IN  stim value of the first mismatch
first_err_valid  output  1  first_err_vec is meaningful

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - stim, busy, done, pass, err_count, first_err_vec and first_err_valid all = 0.
  - Internal hold counter = 0, latched table = 0.
- States: IDLE, RUN, FIN.
- IDLE:
  - stim = 0, busy = 0.
  - On a clk edge with start = 1:
    - latch expect_tt into an internal table;
    - stim <= 0, hold_cnt <= HOLD-1;
    - clear err_count, pass, first_err_valid and first_err_vec;
    - busy <= 1, go to RUN.
- RUN, each edge:
  - If hold_cnt != 0: hold_cnt decrements and stim is unchanged.
  - If hold_cnt == 0 (sample edge): compare resp against table[stim].
  - On mismatch: err_count++.
  - On mismatch with first_err_valid = 0: first_err_vec <= stim, first_err_valid <= 1.
  - If stim != 2^N_IN-1: stim++, hold_cnt <= HOLD-1.
  - Otherwise: go to FIN.
    - busy <= 0, done <= 1.
    - pass <= (no mismatch in the whole sweep, including this final sample).
    - stim <= 0.
- FIN: lasts one cycle; done <= 0; return to IDLE.
  - start in FIN is ignored.
  - A new start is accepted from the following IDLE cycle.
- Timing:
  - busy is high for exactly 2^N_IN*HOLD cycles.
  - done rises on the edge after the final sample edge's cycle, coincident with busy falling.
  - Each vector is stable for HOLD full cycles before its sample edge.
- start while busy: ignored, no restart.
- expect_tt changes mid-sweep: no effect, because the table is latched at start.
- Reset mid-sweep: immediate return to IDLE with all outputs cleared; the partial results are lost.
- Mismatch is bitwise inequality across all N_OUT bits; one count per vector, regardless of how many bits differ.
- err_count is unsigned. first_err_vec and first_err_valid hold their values after the sweep until the next start.

Test Plan:
- N_IN=3, N_OUT=1, HOLD=1, DUT = 3-input majority, expect_tt = 8'b1110_1000, pulse start -> stim steps 0..7 one per cycle; busy high 8 cycles; done pulses; pass=1, err_count=0, first_err_valid=0.
- Same setup, resp tied to 0 -> err_count=4, first_err_vec=3'd3, first_err_valid=1, pass=0.
- HOLD=3, majority DUT -> busy high 24 cycles; each stim value stable 3 cycles; pass=1.
- N_OUT=2, DUT = {A&B, A^B} with matching table, then a table with entry 5 corrupted -> first run pass=1; second run err_count=1, first_err_vec=5.
- Assert rst_n low during stim=4, release, then start again -> all outputs 0 immediately on reset; second sweep completes normally with pass=1.
- Pulse start at stim=2 mid-sweep and again in the FIN cycle -> no restart and exactly one done pulse; start in the following IDLE cycle launches a fresh sweep that clears err_count.
